// File: rtl/display_pkg.sv
// Shared constants and state encoding for the display arbiter.
// Defaults here feed the parameters of every display_arbiter file.
package display_pkg;

    localparam int DEF_N_REQ     = 3;
    localparam int DEF_WIDTHADDR = 4;
    localparam int DEF_WIDTHDATA = 24;
    localparam int DEF_TIMEOUT   = 25000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LATCH = ST_LATCH,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle between requesters, arbiter and display sequencer.
// master = arbiter side, slave = requesters/sequencer side.
interface display_arbiter_if
    import display_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTHADDR = DEF_WIDTHADDR,
    parameter int WIDTHDATA = DEF_WIDTHDATA
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ*WIDTHADDR-1:0] addr_begin;
    logic [N_REQ*WIDTHADDR-1:0] addr_end;
    logic [N_REQ*WIDTHDATA-1:0] data;
    logic                       disp_done;
    logic [N_REQ-1:0]           grant;
    logic [N_REQ-1:0]           done;
    logic                       err;
    logic                       disp_start;
    logic [WIDTHADDR-1:0]       disp_addr_begin;
    logic [WIDTHADDR-1:0]       disp_addr_end;
    logic [WIDTHDATA-1:0]       disp_data;

    modport master (
        input  req, addr_begin, addr_end, data, disp_done,
        output grant, done, err, disp_start,
        output disp_addr_begin, disp_addr_end, disp_data
    );

    modport slave (
        output req, addr_begin, addr_end, data, disp_done,
        input  grant, done, err, disp_start,
        input  disp_addr_begin, disp_addr_end, disp_data
    );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or after ptr.
// Produces one-hot winner, its index and an any-request flag.
module rr_select
    import display_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);
    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_any = 1'b1;
                o_idx = IW'((int'(i_ptr) + i) % N_REQ);
                o_winner[(int'(i_ptr) + i) % N_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter granting one requester at a time the display
// sequencer; latches its command range and payload for the transaction.
module display_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTHADDR = DEF_WIDTHADDR,
    parameter int WIDTHDATA = DEF_WIDTHDATA,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTHADDR-1:0] i_addr_begin,
    input  logic [N_REQ*WIDTHADDR-1:0] i_addr_end,
    input  logic [N_REQ*WIDTHDATA-1:0] i_data,
    input  logic                       i_disp_done,
    output logic [N_REQ-1:0]           o_grant,
    output logic [N_REQ-1:0]           o_done,
    output logic                       o_err,
    output logic                       o_disp_start,
    output logic [WIDTHADDR-1:0]       o_addr_begin,
    output logic [WIDTHADDR-1:0]       o_addr_end,
    output logic [WIDTHDATA-1:0]       o_data
);
    localparam int IW = idx_w(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               r_state;
    state_t               w_next;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_ptr;
    logic [CW-1:0]        r_cnt;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     r_done;
    logic                 r_err;
    logic                 r_start;
    logic [WIDTHADDR-1:0] r_abeg;
    logic [WIDTHADDR-1:0] r_aend;
    logic [WIDTHDATA-1:0] r_data;

    logic [N_REQ-1:0]     w_win_oh;
    logic [IW-1:0]        w_win_idx;
    logic                 w_any;
    logic [WIDTHADDR-1:0] w_beg;
    logic [WIDTHADDR-1:0] w_end;
    logic [WIDTHDATA-1:0] w_data;
    logic                 w_bad;
    logic                 w_tmo;
    logic [IW-1:0]        w_ptr_nxt;

    rr_select #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_winner (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    assign w_beg  = i_addr_begin[r_owner*WIDTHADDR +: WIDTHADDR];
    assign w_end  = i_addr_end[r_owner*WIDTHADDR +: WIDTHADDR];
    assign w_data = i_data[r_owner*WIDTHDATA +: WIDTHDATA];
    assign w_bad  = w_beg > w_end;
    assign w_tmo  = r_cnt == CW'(TIMEOUT - 1);

    assign w_ptr_nxt = (r_owner == IW'(N_REQ - 1)) ? '0
                                                    : r_owner + IW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_LATCH;
            S_LATCH: w_next = w_bad ? S_DONE : S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (i_disp_done || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pulses default low; they rise only on the transition that earns them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_abeg  <= '0;
            r_aend  <= '0;
            r_data  <= '0;
        end else begin
            r_done  <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) r_owner <= w_win_idx;
                end
                S_LATCH: begin
                    r_abeg  <= w_beg;
                    r_aend  <= w_end;
                    r_data  <= w_data;
                    r_grant <= N_REQ'(1) << r_owner;
                    r_err   <= w_bad;
                    r_start <= !w_bad;
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (i_disp_done) r_done <= r_grant;
                    else if (w_tmo)  r_err  <= 1'b1;
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign o_grant      = r_grant;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_disp_start = r_start;
    assign o_addr_begin = r_abeg;
    assign o_addr_end   = r_aend;
    assign o_data       = r_data;

    logic w_unused;
    assign w_unused = ^w_win_oh;
endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: vector table plus
// hand-written multi-cycle sequences, checked through a scoreboard.
module tb_display_arbiter;
    import display_pkg::*;

    localparam int N  = 3;
    localparam int WA = 4;
    localparam int WD = 24;
    localparam int TO = 50;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*WA-1:0] abeg;
        logic [N*WA-1:0] aend;
        logic [N*WD-1:0] data;
        int              delay;
        logic [N-1:0]    e_grant;
        logic [WA-1:0]   e_abeg;
        logic [WA-1:0]   e_aend;
        logic [WD-1:0]   e_data;
        logic            e_err;
    } vec_t;

    typedef struct {
        logic [N-1:0]  grant;
        logic [WA-1:0] abeg;
        logic [WA-1:0] aend;
        logic [WD-1:0] data;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    vec_t vt[8];

    display_arbiter_if #(.N_REQ(N), .WIDTHADDR(WA), .WIDTHDATA(WD)) bus();

    display_arbiter #(
        .N_REQ     (N),
        .WIDTHADDR (WA),
        .WIDTHDATA (WD),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (bus.req),
        .i_addr_begin (bus.addr_begin),
        .i_addr_end   (bus.addr_end),
        .i_data       (bus.data),
        .i_disp_done  (bus.disp_done),
        .o_grant      (bus.grant),
        .o_done       (bus.done),
        .o_err        (bus.err),
        .o_disp_start (bus.disp_start),
        .o_addr_begin (bus.disp_addr_begin),
        .o_addr_end   (bus.disp_addr_end),
        .o_data       (bus.disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
    endtask

    // Wait for start/err, compare against the scoreboard, finish txn.
    task automatic serve(input int delay, input bit drop, input int lat);
        exp_t e;
        int   k;
        bit   seen;
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!seen && (bus.disp_start || bus.err)) begin
                seen = 1'b1;
                k = i;
                break;
            end
        end
        check("start_or_err_seen", 64'(seen), 64'd1);
        if (!seen) return;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        if (lat >= 0) check("latency", 64'(k), 64'(lat));
        check("grant", 64'(bus.grant), 64'(e.grant));
        check("addr_begin", 64'(bus.disp_addr_begin), 64'(e.abeg));
        check("addr_end", 64'(bus.disp_addr_end), 64'(e.aend));
        check("data", 64'(bus.disp_data), 64'(e.data));
        check("err", 64'(bus.err), 64'(e.err));
        if (drop) bus.req = '0;
        if (bus.disp_start) begin
            tick();
            check("start_one_cycle", 64'(bus.disp_start), 64'd0);
            repeat (delay - 1) tick();
            pulse_done();
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (!seen && bus.done != '0) seen = 1'b1;
                else if (!seen) tick();
            end
            check("done_pulse", 64'(bus.done), 64'(e.grant));
            tick();
            check("done_once", 64'(bus.done), 64'd0);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                if (bus.disp_start || bus.done != '0 || bus.err) seen = 1'b1;
            end
            check("bad_range_quiet", 64'(seen), 64'd0);
        end
    endtask

    initial begin
        int   n;
        bit   bad;
        exp_t e;
        int   mptr;

        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.disp_done = 1'b0;
        bus.addr_begin = {4'd2, 4'd1, 4'd6};
        bus.addr_end   = {4'd5, 4'd3, 4'd9};
        bus.data       = {24'h555555, 24'hABCDEF, 24'h000FFF};

        vt[0] = '{3'b001, {4'd2,4'd1,4'd6}, {4'd5,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 10,
                  3'b001, 4'd6, 4'd9, 24'h000FFF, 1'b0};
        vt[1] = '{3'b010, {4'd2,4'd1,4'd6}, {4'd5,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 3,
                  3'b010, 4'd1, 4'd3, 24'hABCDEF, 1'b0};
        vt[2] = '{3'b101, {4'd2,4'd1,4'd6}, {4'd5,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 1,
                  3'b100, 4'd2, 4'd5, 24'h555555, 1'b0};
        vt[3] = '{3'b110, {4'd2,4'd1,4'd6}, {4'd5,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 2,
                  3'b010, 4'd1, 4'd3, 24'hABCDEF, 1'b0};
        vt[4] = '{3'b100, {4'd9,4'd1,4'd6}, {4'd6,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 1,
                  3'b100, 4'd9, 4'd6, 24'h555555, 1'b1};
        vt[5] = '{3'b011, {4'd9,4'd1,4'd6}, {4'd6,4'd3,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 1,
                  3'b001, 4'd6, 4'd9, 24'h000FFF, 1'b0};
        vt[6] = '{3'b001, {4'd2,4'd1,4'd15}, {4'd5,4'd3,4'd15},
                  {24'h555555,24'hABCDEF,24'hFFFFFF}, 4,
                  3'b001, 4'd15, 4'd15, 24'hFFFFFF, 1'b0};
        vt[7] = '{3'b111, {4'd2,4'd0,4'd6}, {4'd5,4'd0,4'd9},
                  {24'h555555,24'hABCDEF,24'h000FFF}, 2,
                  3'b010, 4'd0, 4'd0, 24'hABCDEF, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs",
              64'({bus.grant, bus.done, bus.err, bus.disp_start,
                   bus.disp_addr_begin, bus.disp_addr_end}), 64'd0);
        check("reset_data", 64'(bus.disp_data), 64'd0);

        pulse_done();
        repeat (2) tick();
        check("idle_done_ignored", 64'({bus.done, bus.err}), 64'd0);

        for (int v = 0; v < 8; v++) begin
            bus.addr_begin = vt[v].abeg;
            bus.addr_end   = vt[v].aend;
            bus.data       = vt[v].data;
            bus.req        = vt[v].req;
            sb.push_back('{vt[v].e_grant, vt[v].e_abeg, vt[v].e_aend,
                           vt[v].e_data, vt[v].e_err});
            serve(vt[v].delay, 1'b1, 2);
            repeat (2) tick();
            check("idle_grant", 64'(bus.grant), 64'd0);
        end

        // Owner rewrites its payload while the display is busy.
        bus.addr_begin = {4'd2, 4'd1, 4'd6};
        bus.addr_end   = {4'd5, 4'd3, 4'd9};
        bus.data       = {24'h555555, 24'hABCDEF, 24'h000FFF};
        bus.req        = 3'b001;
        n = 0;
        while (!bus.disp_start && n < 8) begin
            tick();
            n++;
        end
        check("stab_start", 64'(bus.disp_start), 64'd1);
        bus.req = '0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) bus.data = {24'h555555, 24'hABCDEF, 24'h00F000};
            if (bus.disp_data !== 24'h000FFF) bad = 1'b1;
        end
        check("stab_hold_wait", 64'(bad), 64'd0);
        pulse_done();
        check("stab_done", 64'(bus.done), 64'd1);
        check("stab_hold_done", 64'(bus.disp_data), 64'h000FFF);
        bus.data = {24'h555555, 24'hABCDEF, 24'h000FFF};
        repeat (3) tick();

        // Never answer: expect err TO cycles after WAIT entry.
        bus.req = 3'b001;
        n = 0;
        while (!bus.disp_start && n < 8) begin
            tick();
            n++;
        end
        check("tmo_start", 64'(bus.disp_start), 64'd1);
        bus.req = '0;
        n = 0;
        bad = 1'b0;
        while (!bus.err && n < TO + 10) begin
            tick();
            n++;
            if (bus.done != '0) bad = 1'b1;
        end
        check("tmo_cycles_after_wait", 64'(n - 1), 64'(TO));
        check("tmo_no_done", 64'(bad), 64'd0);
        tick();
        check("tmo_err_once", 64'(bus.err), 64'd0);
        check("tmo_grant_released", 64'(bus.grant), 64'd0);
        repeat (2) tick();

        // Reset during WAIT aborts silently.
        bus.req = 3'b010;
        n = 0;
        while (!bus.disp_start && n < 8) begin
            tick();
            n++;
        end
        check("rst_start_grant", 64'(bus.grant), 64'b010);
        bus.req = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_outputs",
              64'({bus.grant, bus.done, bus.err, bus.disp_start,
                   bus.disp_addr_begin, bus.disp_addr_end}), 64'd0);
        check("rst_data", 64'(bus.disp_data), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pulse_done();
            else tick();
            if (bus.done != '0 || bus.err) bad = 1'b1;
        end
        check("rst_no_pulse", 64'(bad), 64'd0);

        // Contention after reset: model round-robin from ptr 0.
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            e.grant = 3'(1 << mptr);
            e.abeg  = bus.addr_begin[mptr*WA +: WA];
            e.aend  = bus.addr_end[mptr*WA +: WA];
            e.data  = bus.data[mptr*WD +: WD];
            e.err   = 1'b0;
            sb.push_back(e);
            mptr = (mptr + 1) % N;
        end
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) serve(1, i == 3, (i == 0) ? 2 : -1);
        repeat (3) tick();
        check("cont_idle_grant", 64'(bus.grant), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
